// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: data width, the buffer
// FSM state encoding and the bit period used by benches.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_BIT_CYCLES = 218;

    // IDLE: nothing stored; ARMED: head presented, waiting for transmitted
    // to rise; HOLD: head popped, waiting for transmitted to fall.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } uart_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 storage for the UART transmit buffer: one synchronous write
// port and one asynchronous (combinational) read port. No reset; the
// pointers and count in the parent decide what is valid.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [UART_DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]          raddr_i,
    output logic [UART_DATA_W-1:0] rdata_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    // Synchronous write of one byte per cycle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter. The head byte is held on tx_data
// for the whole frame and popped once per rising edge of tx_transmitted.
// Optional feature macro: UART_TX_BUF_OVF_EN enables the sticky overflow
// flag (cleared by ovf_clr); without it overflow is tied to 0.
//
// Handshake: tx_ready=1 means tx_data holds a valid head byte that stays
// stable until the transmitter signals completion with a rising edge on
// tx_transmitted; the byte is consumed on the following clock edge.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [UART_DATA_W-1:0]     wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [UART_DATA_W-1:0]     tx_data,
    output logic                       tx_ready,
    input  logic                       tx_transmitted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   trans_q;
    uart_state_e            state_q, state_d;
    logic                   rise;
    logic                   pop;
    logic                   wr_accept;
    logic                   wr_drop;
    logic                   empty_w;
    logic                   full_w;
    logic [UART_DATA_W-1:0] rd_data;

    assign empty_w   = (count_q == '0);
    assign full_w    = (count_q == CW'(DEPTH));
    assign rise      = tx_transmitted & ~trans_q;
    assign wr_accept = wr_en & (~full_w | pop);
    assign wr_drop   = wr_en & full_w & ~pop;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Next pointer and count values; a simultaneous write and pop leaves count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_accept && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr_accept) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer, count and transmitted-edge registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            trans_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            trans_q  <= tx_transmitted;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: arm on the first write, hold after a pop until transmitted falls.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_accept) state_d = ARMED;
            ARMED:   if (pop) state_d = HOLD;
            HOLD:    if (!tx_transmitted) state_d = (count_d != '0) ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: only a rising edge seen in ARMED with data stored pops the head.
    always_comb begin
        pop = 1'b0;
        if (state_q == ARMED) begin
            pop = rise & ~empty_w;
        end
    end

`ifdef UART_TX_BUF_OVF_EN
    logic overflow_q;

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (wr_drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr | wr_drop;
    assign overflow   = 1'b0;
`endif

    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;
    assign tx_ready = ~empty_w;
    assign tx_data  = empty_w ? '0 : rd_data;

endmodule
